// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types for the RV32M multiply/divide sequencer.
//   muldiv_op_e    : the eight M-extension Funct3 encodings
//   muldiv_state_e : sequencer FSM states
//   MULDIV_FUNCT7  : Funct7 value that routes an R-type op to this block
//   op_is_div      : true for DIV/DIVU/REM/REMU
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    // Funct3[2] separates the divide family from the multiply family.
    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// -----------------------------------------------------------------------------
// muldiv_iter_core
// One combinational iteration step shared by multiply and divide.
//   i_is_div : 0 = shift-add multiply step, 1 = restoring divide step
//   i_hi     : multiply: product high half  / divide: partial remainder
//   i_lo     : multiply: product low half (multiplier shifts out of bit 0)
//              divide  : dividend shifting out of the MSB, quotient in at LSB
//   i_opnd   : multiplicand magnitude / divisor magnitude
//   o_hi/o_lo: next values of i_hi/i_lo
// -----------------------------------------------------------------------------
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // keeping the carry so the {carry,hi,lo} >> 1 never loses a bit.
    assign w_sum = {1'b0, i_hi} + {1'b0, (i_lo[0] ? i_opnd : '0)};

    // Divide: remainder shifted left with the next dividend bit; it can be
    // WIDTH+1 bits wide when the divisor is large, so compare at that width.
    assign w_shift = {i_hi, i_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_opnd});

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        if (i_is_div) begin
            if (w_ge) begin
                // Difference is below the divisor, so WIDTH bits suffice.
                o_hi = w_shift[WIDTH-1:0] - i_opnd;
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_shift[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative RV32M sequencer for the EX stage: WIDTH-cycle shift-add multiply
// or restoring divide on operand magnitudes, followed by a sign-fix cycle.
// Divide-by-zero and signed overflow finish one cycle after accept.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start        : M-op request, sampled in IDLE only
//   i_funct3       : op select, i_op_a/i_op_b : rs1/rs2 values
//   i_flush        : abort whatever is in flight
//   o_stall        : freeze PC, IF/ID and ID/EX
//   o_done         : one-cycle result strobe, o_result valid while high
//   o_result       : result, holds between strobes
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int               CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e     r_state;
    muldiv_op_e        r_op;
    logic [CNT_W-1:0]  r_count;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_opnd;
    logic              r_neg_q;   // product / quotient negate
    logic              r_neg_r;   // remainder negate (dividend sign)
    logic              r_done;
    logic [WIDTH-1:0]  r_result;

    muldiv_op_e        w_op;
    logic              w_is_div;
    logic              w_sa;
    logic              w_sb;
    logic [WIDTH-1:0]  w_abs_a;
    logic [WIDTH-1:0]  w_abs_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_fast;
    logic [WIDTH-1:0]  w_fast_res;
    logic [WIDTH-1:0]  w_hi_nxt;
    logic [WIDTH-1:0]  w_lo_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]  w_quo_s;
    logic [WIDTH-1:0]  w_rem_s;
    logic [WIDTH-1:0]  w_fix_res;

    // ---------------- accept-time decode ----------------
    assign w_op     = muldiv_op_e'(i_funct3);
    assign w_is_div = op_is_div(w_op);

    // op_a is signed for MULH, MULHSU, DIV, REM; op_b for MULH, DIV, REM.
    assign w_sa = i_op_a[WIDTH-1] &
                  ((w_op == OP_MULH) | (w_op == OP_MULHSU) | (w_op == OP_DIV) | (w_op == OP_REM));
    assign w_sb = i_op_b[WIDTH-1] &
                  ((w_op == OP_MULH) | (w_op == OP_DIV) | (w_op == OP_REM));

    // Most-negative input wraps to itself, which is its correct unsigned magnitude.
    assign w_abs_a = w_sa ? -i_op_a : i_op_a;
    assign w_abs_b = w_sb ? -i_op_b : i_op_b;

    assign w_div0 = w_is_div & (i_op_b == '0);
    assign w_ovf  = ((w_op == OP_DIV) | (w_op == OP_REM)) & (i_op_a == MIN_NEG) & (i_op_b == '1);
    assign w_fast = w_div0 | w_ovf;

    // Funct3[1] picks REM/REMU over DIV/DIVU.
    assign w_fast_res = w_div0 ? (i_funct3[1] ? i_op_a : '1)
                               : (i_funct3[1] ? '0     : i_op_a);

    // ---------------- iteration datapath ----------------
    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .i_is_div (op_is_div(r_op)),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_hi_nxt),
        .o_lo     (w_lo_nxt)
    );

    // ---------------- sign fix / result select ----------------
    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo_s  = r_neg_q ? -r_lo   : r_lo;
    assign w_rem_s  = r_neg_r ? -r_hi   : r_hi;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            OP_MUL:                       w_fix_res = w_prod_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              w_fix_res = w_quo_s;
            default:                      w_fix_res = w_rem_s;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (i_flush) begin
            // Abort: no strobe, result keeps its previous value.
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_op    <= w_op;
                        r_count <= '0;
                        r_hi    <= '0;
                        // Multiply: multiplier in lo, multiplicand added.
                        // Divide: dividend in lo, divisor subtracted.
                        r_lo    <= w_is_div ? w_abs_a : w_abs_b;
                        r_opnd  <= w_is_div ? w_abs_b : w_abs_a;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_hi    <= w_hi_nxt;
                    r_lo    <= w_lo_nxt;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(WIDTH - 1))
                        r_state <= FIX;
                end
                FIX: begin
                    r_result <= w_fix_res;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_stall  = ((r_state == IDLE) & i_start & ~i_flush) | (r_state == RUN) | (r_state == FIX);
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   funct3;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic         stall;
    logic         done;
    logic [W-1:0] result;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (start),
        .i_funct3 (funct3),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_flush  (flush),
        .o_stall  (stall),
        .o_done   (done),
        .o_result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
        string        name;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic         prev_done = 1'b0;
    logic [W-1:0] last_exp  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                tests++;
                if (prev_done) begin
                    fails++;
                    $display("FAIL done_twice: done high in consecutive cycles at cycle %0d", cyc);
                end
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: result=%h at cycle %0d with no request pending", result, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    if (result !== mon_e.res || cyc != mon_e.cyc) begin
                        fails++;
                        $display("FAIL %s: got result=%h cycle=%0d, expected result=%h cycle=%0d",
                                 mon_e.name, result, cyc, mon_e.res, mon_e.cyc);
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Issue one op; start stays high until the done cycle, as the stalled
    // pipeline would hold it.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        exp_t e;
        int   bad;
        bit   seen;
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        #1;
        check({name, "_stall_acc"}, W'(stall), W'(1));
        e.res = exp; e.cyc = cyc + lat; e.name = name;
        sbq.push_back(e);
        last_exp = exp;
        bad = 0; seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (!stall) bad++;
        end
        check({name, "_done_seen"}, W'(seen), W'(1));
        check({name, "_stall_run_drops"}, W'(bad), W'(0));
        check({name, "_stall_in_done"}, W'(stall), W'(0));
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", W'(done), W'(0));
        check("rst_result", result, '0);
        check("rst_stall", W'(stall), W'(0));
        reset = 1'b0;

        // Iterative ops, latency 34
        run_op("mul_7x-3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("mulhu_ff",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("mulh_ff",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
        run_op("mulhsu_ff",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        run_op("mulh_minneg",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("div_-20_3",    3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 34);
        run_op("rem_-20_3",    3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 34);
        run_op("divu_20_3",    3'b101, 32'd20,       32'd3,        32'd6,        34);
        run_op("remu_20_3",    3'b111, 32'd20,       32'd3,        32'd2,        34);
        run_op("div_7_-2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        run_op("rem_7_-2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34);
        run_op("divu_max_1",   3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34);
        run_op("remu_max_big", 3'b111, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 34);

        // Fast paths, latency 1
        run_op("divu_5_0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_5_0",      3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Flush at RUN cycle 10: no strobe, result holds, stall drops.
        @(negedge clk);
        funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("flush_stall", W'(stall), W'(0));
        check("flush_done", W'(done), W'(0));
        check("flush_result", result, last_exp);
        repeat (40) @(negedge clk);
        check("flush_no_strobe_result", result, last_exp);
        run_op("mul_2x3_after_flush", 3'b000, 32'd2, 32'd3, 32'd6, 34);

        // Reset at RUN cycle 5 with start held high across RUN.
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check("midrst_done", W'(done), W'(0));
        check("midrst_result", result, '0);
        check("midrst_stall", W'(stall), W'(0));
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_strobe_result", result, '0);
        run_op("mulhu_after_rst", 3'b011, 32'h00010000, 32'h00010000, 32'd1, 34);

        repeat (5) @(negedge clk);
        check("sb_drain", W'(sbq.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative controller/datapath sequencer for the RV32M instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits in the EX stage beside the ALU. The main controller raises `start` when ALUOp selects the M-extension (Funct7 = 0000001). This block then stalls the pipeline while it runs a shift-add multiply or a restoring divide.
- It returns a single-cycle result strobe that EX muxes in place of the ALU result.

Parameters:
- WIDTH, 32, operand and result width. Must be ≥ 4; the count register is clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; all state clears on a rising edge of clk while high.
- start  in  1  request from EX. Sampled only in IDLE; ignored in any other state.
- funct3  in  3  M-extension op code (Funct3 field). Captured with the operands on accept.
- op_a  in  WIDTH  rs1 value (multiplicand / dividend). Captured on accept.
- op_b  in  WIDTH  rs2 value (multiplier / divisor). Captured on accept.
- flush  in  1  branch/jump flush from the hazard unit. Aborts any operation in flight.
- stall  out  1  holds the PC, IF/ID and ID/EX registers.
- done  out  1  one-cycle strobe; result is valid while done = 1.
- result  out  WIDTH  final value; holds its last value when done = 0.

Behaviour:
- States:
  - IDLE → RUN on accept (start=1, flush=0) when not a fast-path case.
  - IDLE → DONE on accept when a fast-path case applies.
  - RUN → FIX when count = WIDTH−1.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- Accept cycle (start=1 in IDLE):
  - Latch funct3.
  - Latch |op_a| and |op_b| according to signedness: MULH and DIV/REM are signed on both operands; MULHSU is signed on op_a only; the rest are unsigned.
  - Latch the result-negate flags and set count=0.
- stall:
  - Combinational: stall = (IDLE & start & ~flush) | RUN | FIX.
  - stall is 0 in DONE, so the instruction advances in the same cycle that done = 1.
- RUN, multiply: a 2·WIDTH-bit product register; add-and-shift one bit per cycle.
- RUN, divide: restoring divide, one quotient bit per cycle into a WIDTH-bit remainder and quotient.
- count:
  - Increments every RUN cycle.
  - Exactly WIDTH RUN cycles are performed; there is no early termination.
- FIX:
  - Apply two's-complement negation per the latched flags. Product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa (the dividend sign).
  - Select the result: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
- Latency from the accept edge to done = 1: WIDTH+2 cycles (34 for WIDTH=32). Fast path latency: 1 cycle.
- Fast paths (resolved at accept, skip RUN/FIX):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow: DIV with op_a = 1 followed by zeros and op_b = all-ones gives op_a; REM in the same case gives 0.
  - Multiply has no fast path.
- flush:
  - Any state → IDLE next cycle.
  - done is not asserted, result is unchanged, and stall deasserts in the same cycle.
  - flush together with start in IDLE means no accept.
- Reset, including mid-operation:
  - State = IDLE, count = 0, done = 0, result = 0, all latches cleared.
  - stall is then 0 unless start is high.
- start is held high by the stalled pipeline during RUN/FIX; it is ignored there.
- In DONE, start is ignored. A back-to-back M instruction is accepted in the following IDLE cycle.
- done is never asserted for two consecutive cycles.
- All arithmetic is modulo 2^WIDTH except the internal 2·WIDTH-bit product. Negation of the most-negative value wraps to itself.

Decomposition:
- Shared package `muldiv_pkg`:
  - `muldiv_op_e` enum of the 8 funct3 encodings.
  - `muldiv_state_e` enum {IDLE, RUN, FIX, DONE}.
  - Constant `MULDIV_FUNCT7 = 7'b0000001`.
- One sub-module, `muldiv_iter_core`:
  - The per-cycle shift-add and restoring-subtract datapath step.
  - Purely combinational: takes the current partial registers and the op class, returns the next partial registers.
- The FSM, count, latches and FIX logic live in the top module.

Test Plan:
- MUL with op_a=7, op_b=−3 → stall high for 33 cycles from accept, done at accept+34, result=0xFFFFFFEB; stall=0 during the done cycle.
- MULHU with 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3 → result=0xFFFFFFFA (−6). REM −20/3 → 0xFFFFFFFE (−2). DIVU 20/3 → 6. REMU 20/3 → 2. Each at latency 34.
- DIVU 5/0 → done at accept+1, result=0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000 at latency 1. REM in the same case → 0.
- Start DIV, assert flush at RUN cycle 10 → IDLE next cycle, no done strobe, result unchanged, stall=0. A new MUL 2×3 then completes with result 6.
- Assert reset at RUN cycle 5 → after the edge: state IDLE, done=0, result=0, stall=0 with start low. start held high across RUN is never re-accepted.
